mem_wb_pipe: RTL and testbench
==============================

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 10: write-back data width per lane.
REQ-002 Parameter REG_W, default 3: register-index width per lane.
REQ-003 Parameter LANES, default 1: independent write-back lanes carried per transfer.
REQ-004 Parameter R0_HARDWIRED, default 1: when 1, a lane writing register index 0 has its enable forced to 0 on capture.
REQ-005 The clock and reset SHALL be: one clock; reset is asynchronous and active-low. Ports: clk (rising edge) and rst (asynchronous, active-low).
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  async active-low reset.
REQ-008 in_valid  in  1  upstream (MEM) transfer offered.
REQ-009 in_ready  out  1  stage can accept; registered.
REQ-010 in_data  in  LANES*DATA_W  per-lane write data, lane 0 in LSBs.
REQ-011 in_en  in  LANES  per-lane write enable.
REQ-012 in_reg  in  LANES*REG_W  per-lane destination index.
REQ-013 flush  in  1  discard all held entries.
REQ-014 out_valid  out  1  head entry valid toward WB/register file.
REQ-015 out_ready  in  1  downstream accepts head.
REQ-016 out_data, out_en, out_reg  out  same widths as inputs  head entry fields; out_en gated by out_valid.
REQ-017 fwd_reg  in  REG_W  bypass query index.
REQ-018 fwd_hit  out  1  combinational: some head lane has out_valid, enable 1, index == fwd_reg.
REQ-019 fwd_data  out  DATA_W  data of the highest-numbered hitting lane; 0 when no hit.

Function
REQ-020 Storage SHALL be a two-entry skid buffer (head, skid); states EMPTY, ONE, FULL.
REQ-021 Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same rising edge.
REQ-022 EMPTY: push -> ONE (head loaded); else stay.
REQ-023 ONE: push&!pop -> FULL (skid loaded); !push&pop -> EMPTY; push&pop -> ONE (head reloaded from input); neither -> ONE.
REQ-024 FULL: pop -> ONE (head <= skid); no push possible; else stay.
REQ-025 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, registered from next state (no combinational path from out_ready).
REQ-026 out_valid SHALL be 1 in ONE and FULL; head fields are stable while out_valid & !out_ready.
REQ-027 Latency: data pushed into EMPTY appears on out_* one cycle later.
REQ-028 Throughput: one transfer per cycle when out_ready is held 1.
REQ-029 Order preserved; no entry duplicated or dropped except by flush.
REQ-030 R0_HARDWIRED=1: capture stores en=0 for any lane with reg==0; data/reg still stored.
REQ-031 flush=1 SHALL force next state EMPTY, next in_ready 1, and drop any concurrent push; a concurrent pop still completes downstream.
REQ-032 Lanes SHALL be independent; lane enables never affect handshake.

Reset
REQ-033 While rst=0: state EMPTY, out_valid 0, in_ready 0, head/skid data, en, reg all 0.
REQ-034 First rising clk after rst deasserts SHALL set in_ready 1; in_valid ignored until in_ready is 1.
REQ-035 Reset asserted mid-transfer SHALL discard all entries immediately (asynchronously).

Structure
REQ-036 Shared package mem_wb_pkg SHALL hold the state enumeration (EMPTY, ONE, FULL) and default DATA_W/REG_W constants.
REQ-037 One sub-module, wb_fwd_match, SHALL implement the fwd_hit/fwd_data lane compare and priority select.

Verification
REQ-038 Reset: rst=0 with in_valid=1 -> out_valid 0, in_ready 0; release -> in_ready 1 next edge.
REQ-039 Stream: LANES=1, out_ready=1, push data 0x3FF,0x001,0x155 on consecutive cycles -> same order on out_data, one cycle later each, in_ready never 0.
REQ-040 Backpressure: out_ready=0, push A=0x0AA then B=0x155 -> FULL, in_ready 0, out_data holds 0x0AA; out_ready=1 -> 0x0AA then 0x155 output, in_ready 1.
REQ-041 R0 suppression: push en=1 reg=0 data=0x2A5 -> out_en 0, out_reg 0, out_data 0x2A5; reg=5 -> out_en 1.
REQ-042 Flush: FULL with push offered and flush=1 -> next cycle EMPTY, out_valid 0, in_ready 1, offered entry never appears.
REQ-043 Forward: LANES=2, head lane0 {en1,reg3,0x011}, lane1 {en1,reg3,0x022}, fwd_reg=3 -> fwd_hit 1, fwd_data 0x022; fwd_reg=4 -> hit 0, data 0.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared state encoding and default widths for the MEM/WB pipeline stage.
package mem_wb_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_REG_W = 3;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: compares each head lane against the bypass index; the highest matching lane wins.
module wb_fwd_match #(
  parameter int DATA_W = 10,
  parameter int REG_W = 3,
  parameter int LANES = 1
) (
  input  logic [LANES-1:0]        en,
  input  logic [LANES*REG_W-1:0]  idx,
  input  logic [LANES*DATA_W-1:0] data,
  input  logic [REG_W-1:0]        fwd_reg,
  output logic                    hit,
  output logic [DATA_W-1:0]       fwd_data
);
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (en[i] && idx[i*REG_W +: REG_W] == fwd_reg) begin
        hit = 1'b1;
        fwd_data = data[i*DATA_W +: DATA_W];
      end
    end
  end
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: two-entry skid buffer carrying multi-lane write-back results with a head bypass port.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W = DEF_REG_W,
  parameter int LANES = 1,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_en,
  input  logic [LANES*REG_W-1:0]  in_reg,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_en,
  output logic [LANES*REG_W-1:0]  out_reg,
  input  logic [REG_W-1:0]        fwd_reg,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data
);
  state_t state, state_nx;
  logic [LANES*DATA_W-1:0] skid_data;
  logic [LANES*REG_W-1:0]  skid_reg;
  logic [LANES-1:0]        head_en, skid_en, cap_en;
  logic push, pop;
  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_cap
      assign cap_en[g] = in_en[g] & ~(R0_HARDWIRED & (in_reg[g*REG_W +: REG_W] == '0));
    end
  endgenerate
  assign out_valid = state != EMPTY;
  assign out_en = head_en & {LANES{out_valid}};
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready;
  always_comb begin
    state_nx = flush ? EMPTY :
               state == EMPTY ? (push ? ONE : EMPTY) :
               state == ONE ? (push & ~pop ? FULL : ~push & pop ? EMPTY : ONE) :
               (pop ? ONE : FULL);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      in_ready <= 1'b0;
      out_data <= '0;
      out_reg <= '0;
      head_en <= '0;
      skid_data <= '0;
      skid_reg <= '0;
      skid_en <= '0;
    end else begin
      state <= state_nx;
      in_ready <= state_nx != FULL;
      if (push && (state == EMPTY || pop)) begin
        out_data <= in_data;
        out_reg <= in_reg;
        head_en <= cap_en;
      end else if (state == FULL && pop) begin
        out_data <= skid_data;
        out_reg <= skid_reg;
        head_en <= skid_en;
      end
      if (push && state == ONE && !pop) begin
        skid_data <= in_data;
        skid_reg <= in_reg;
        skid_en <= cap_en;
      end
    end
  end
  wb_fwd_match #(.DATA_W(DATA_W), .REG_W(REG_W), .LANES(LANES)) u_fwd (
    .en(out_en), .idx(out_reg), .data(out_data), .fwd_reg(fwd_reg),
    .hit(fwd_hit), .fwd_data(fwd_data)
  );
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: queue-based reference model with per-cycle compare, directed literal checks and random traffic.
module tb_mem_wb_pipe;
  localparam int DW = 10, RW = 3, L = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0, fwd_hit;
  logic [L*DW-1:0] in_data = '0, out_data;
  logic [L-1:0] in_en = '0, out_en;
  logic [L*RW-1:0] in_reg = '0, out_reg;
  logic [RW-1:0] fwd_reg = '0;
  logic [DW-1:0] fwd_data;
  int total = 0, bad = 0;

  typedef struct packed {
    logic [L*DW-1:0] data;
    logic [L-1:0] en;
    logic [L*RW-1:0] idx;
  } ent_t;
  ent_t q[$];
  logic m_rdy = 1'b0;
  logic m_push, m_pop;

  mem_wb_pipe #(.DATA_W(DW), .REG_W(RW), .LANES(L), .R0_HARDWIRED(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_en(in_en), .in_reg(in_reg), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_en(out_en), .out_reg(out_reg), .fwd_reg(fwd_reg),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t capture();
    ent_t e;
    e.data = in_data;
    e.idx = in_reg;
    for (int l = 0; l < L; l++) e.en[l] = in_en[l] && (in_reg[l*RW +: RW] != '0);
    return e;
  endfunction

  // Reference: a FIFO of at most two entries; ready whenever fewer than two remain.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_rdy = 1'b0;
    end else begin
      m_push = in_valid && m_rdy && !flush;
      m_pop = (q.size() > 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (flush) q.delete();
      else if (m_push) q.push_back(capture());
      m_rdy = q.size() < 2;
    end
  end

  always @(negedge clk) begin
    logic hit;
    logic [DW-1:0] fd;
    #1;
    hit = 1'b0;
    fd = '0;
    if (q.size() > 0)
      for (int l = 0; l < L; l++)
        if (q[0].en[l] && q[0].idx[l*RW +: RW] == fwd_reg) begin
          hit = 1'b1;
          fd = q[0].data[l*DW +: DW];
        end
    chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("m_in_ready", 32'(in_ready), 32'(m_rdy));
    chk("m_out_en", 32'(out_en), q.size() > 0 ? 32'(q[0].en) : 32'd0);
    chk("m_fwd_hit", 32'(fwd_hit), 32'(hit));
    chk("m_fwd_data", 32'(fwd_data), 32'(fd));
    if (q.size() > 0) begin
      chk("m_out_data", 32'(out_data), 32'(q[0].data));
      chk("m_out_reg", 32'(out_reg), 32'(q[0].idx));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic put(input logic v, input logic [DW-1:0] d0, input logic e0, input logic [RW-1:0] r0,
                     input logic [DW-1:0] d1, input logic e1, input logic [RW-1:0] r1);
    in_valid = v;
    in_data = {d1, d0};
    in_en = {e1, e0};
    in_reg = {r1, r0};
  endtask

  initial begin
    put(1, 10'h123, 1, 3'd2, 10'h0, 0, 3'd0);
    cyc();
    cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", 32'(in_ready), 0);
    cyc();
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_no_push", 32'(out_valid), 0);

    out_ready = 1'b1;
    put(1, 10'h3FF, 1, 3'd1, 10'h0, 0, 3'd0);
    cyc();
    chk("stream_0", 32'(out_data[DW-1:0]), 32'h3FF);
    chk("stream_rdy0", 32'(in_ready), 1);
    put(1, 10'h001, 1, 3'd1, 10'h0, 0, 3'd0);
    cyc();
    chk("stream_1", 32'(out_data[DW-1:0]), 32'h001);
    chk("stream_rdy1", 32'(in_ready), 1);
    put(1, 10'h155, 1, 3'd1, 10'h0, 0, 3'd0);
    cyc();
    chk("stream_2", 32'(out_data[DW-1:0]), 32'h155);
    chk("stream_rdy2", 32'(in_ready), 1);
    in_valid = 1'b0;
    cyc();
    chk("stream_drained", 32'(out_valid), 0);

    out_ready = 1'b0;
    put(1, 10'h0AA, 1, 3'd1, 10'h0, 0, 3'd0);
    cyc();
    put(1, 10'h155, 1, 3'd1, 10'h0, 0, 3'd0);
    cyc();
    chk("bp_full_rdy", 32'(in_ready), 0);
    chk("bp_hold_a", 32'(out_data[DW-1:0]), 32'h0AA);
    in_valid = 1'b0;
    cyc();
    chk("bp_still_a", 32'(out_data[DW-1:0]), 32'h0AA);
    out_ready = 1'b1;
    cyc();
    chk("bp_then_b", 32'(out_data[DW-1:0]), 32'h155);
    chk("bp_rdy_back", 32'(in_ready), 1);
    cyc();
    chk("bp_empty", 32'(out_valid), 0);

    out_ready = 1'b0;
    put(1, 10'h2A5, 1, 3'd0, 10'h0, 0, 3'd0);
    cyc();
    chk("r0_en", 32'(out_en), 0);
    chk("r0_reg", 32'(out_reg), 0);
    chk("r0_data", 32'(out_data[DW-1:0]), 32'h2A5);
    out_ready = 1'b1;
    put(1, 10'h2A5, 1, 3'd5, 10'h0, 0, 3'd0);
    cyc();
    chk("r5_en", 32'(out_en), 1);
    chk("r5_reg", 32'(out_reg[RW-1:0]), 5);
    in_valid = 1'b0;
    cyc();

    out_ready = 1'b0;
    put(1, 10'h011, 1, 3'd1, 10'h0, 0, 3'd0);
    cyc();
    put(1, 10'h022, 1, 3'd1, 10'h0, 0, 3'd0);
    cyc();
    put(1, 10'h033, 1, 3'd1, 10'h0, 0, 3'd0);
    flush = 1'b1;
    cyc();
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_in_ready", 32'(in_ready), 1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("fl_dropped", 32'(out_valid), 0);
    out_ready = 1'b0;
    put(1, 10'h044, 1, 3'd1, 10'h0, 0, 3'd0);
    cyc();
    put(1, 10'h055, 1, 3'd1, 10'h0, 0, 3'd0);
    flush = 1'b1;
    cyc();
    chk("fl_one_push_dropped", 32'(out_valid), 0);
    flush = 1'b0;
    in_valid = 1'b0;
    cyc();

    put(1, 10'h011, 1, 3'd3, 10'h022, 1, 3'd3);
    cyc();
    in_valid = 1'b0;
    fwd_reg = 3'd3;
    #1;
    chk("fwd_hit3", 32'(fwd_hit), 1);
    chk("fwd_data3", 32'(fwd_data), 32'h022);
    fwd_reg = 3'd4;
    #1;
    chk("fwd_hit4", 32'(fwd_hit), 0);
    chk("fwd_data4", 32'(fwd_data), 0);
    out_ready = 1'b1;
    cyc();

    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 15) == 0);
      in_data = 20'($urandom);
      in_en = 2'($urandom);
      in_reg = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      fwd_reg = 3'($urandom_range(0, 3));
      if (i % 700 == 350) begin
        #1 rst = 1'b0;
        cyc();
        rst = 1'b1;
      end
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
